// File: rtl/vivo_fifo_pp_if.sv
// rtl/vivo_fifo_pp_if.sv - push/pop handshake bundle for the variable-element FIFO
interface vivo_fifo_pp_if #(
  parameter int ELEM_WIDTH    = 8,
  parameter int IN_ELEMS_MAX  = 4,
  parameter int OUT_ELEMS_MAX = 4
);
  localparam int IN_NW  = $clog2(IN_ELEMS_MAX + 1);
  localparam int OUT_NW = $clog2(OUT_ELEMS_MAX + 1);

  // push side
  logic                                in_valid;
  logic                                in_ready;
  logic [IN_ELEMS_MAX*ELEM_WIDTH-1:0]  in_data;
  logic [IN_NW-1:0]                    in_num_elems;

  // pop side
  logic                                out_valid;
  logic                                out_ready;
  logic [OUT_ELEMS_MAX*ELEM_WIDTH-1:0] out_data;
  logic [OUT_NW-1:0]                   out_num_elems;
  logic [OUT_NW-1:0]                   out_req_elems;

  // producer/consumer side
  modport master (
    output in_valid, in_data, in_num_elems, out_ready, out_req_elems,
    input  in_ready, out_valid, out_data, out_num_elems
  );

  // FIFO side
  modport slave (
    input  in_valid, in_data, in_num_elems, out_ready, out_req_elems,
    output in_ready, out_valid, out_data, out_num_elems
  );
endinterface

// File: rtl/vivo_fifo_pp.sv
// rtl/vivo_fifo_pp.sv - variable-in/variable-out element FIFO with registered output stage
module vivo_fifo_pp #(
  parameter int  ELEM_WIDTH    = 8,
  parameter int  DEPTH         = 16,
  parameter int  IN_ELEMS_MAX  = 4,
  parameter int  OUT_ELEMS_MAX = 4,
  parameter int  PARTIAL_POP   = 1,
  localparam int BANKS         = (IN_ELEMS_MAX > OUT_ELEMS_MAX) ? IN_ELEMS_MAX : OUT_ELEMS_MAX,
  localparam int CAPACITY      = DEPTH * BANKS,
  parameter int  AF_THRESH     = CAPACITY - IN_ELEMS_MAX,
  parameter int  AE_THRESH     = OUT_ELEMS_MAX,
  localparam int LVL_W         = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  vivo_fifo_pp_if.slave    bus,
  output logic [LVL_W-1:0] level,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             err_req
);
  localparam int OUT_NW = $clog2(OUT_ELEMS_MAX + 1);
  localparam int IDX_W  = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam int OUT_W  = OUT_ELEMS_MAX * ELEM_WIDTH;

  // element storage is a flat ring; banking is only a sizing notion
  logic [ELEM_WIDTH-1:0] mem_q [CAPACITY];
  logic [ELEM_WIDTH-1:0] mem_d [CAPACITY];

  logic [IDX_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_NW-1:0] out_num_q, out_num_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic              err_q, err_d;

  logic in_ready;
  logic do_push;
  logic do_load;
  int   in_n, req_n, lvl, push_n, grant_n, load_n;

  // indices never exceed 2*CAPACITY-1, so one conditional subtract is a full modulo
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    int t;
    t = (v >= CAPACITY) ? v - CAPACITY : v;
    return IDX_W'(t);
  endfunction

  // push acceptance and output-stage grant; loads see the pre-push level
  always_comb begin
    in_n     = int'(bus.in_num_elems);
    req_n    = int'(bus.out_req_elems);
    lvl      = int'(level_q);
    in_ready = !flush && (in_n != 0) && (in_n <= IN_ELEMS_MAX) && (in_n <= CAPACITY - lvl);
    do_push  = bus.in_valid && in_ready;
    push_n   = do_push ? in_n : 0;
    grant_n  = 0;
    if (req_n >= 1 && req_n <= OUT_ELEMS_MAX) begin
      if (PARTIAL_POP != 0) begin
        grant_n = (req_n < lvl) ? req_n : lvl;
      end else if (lvl >= req_n) begin
        grant_n = req_n;
      end
    end
    do_load = (!out_valid_q || bus.out_ready) && !flush && (grant_n != 0);
    load_n  = do_load ? grant_n : 0;
  end

  // element-wise write so pushes straddling the ring end split without a bubble
  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      for (int j = 0; j < IN_ELEMS_MAX; j++) begin
        if (j < in_n) begin
          mem_d[wrap_idx(int'(wr_q) + j)] = bus.in_data[j*ELEM_WIDTH +: ELEM_WIDTH];
        end
      end
    end
  end

  // pointer, level, output stage, flag and error next-state; flush overrides all
  always_comb begin
    wr_d        = wrap_idx(int'(wr_q) + push_n);
    rd_d        = wrap_idx(int'(rd_q) + load_n);
    level_d     = LVL_W'(lvl + push_n - load_n);
    out_valid_d = out_valid_q;
    out_num_d   = out_num_q;
    out_data_d  = out_data_q;
    if (do_load) begin
      out_valid_d = 1'b1;
      out_num_d   = OUT_NW'(load_n);
      out_data_d  = '0;
      for (int i = 0; i < OUT_ELEMS_MAX; i++) begin
        if (i < load_n) begin
          out_data_d[i*ELEM_WIDTH +: ELEM_WIDTH] = mem_q[wrap_idx(int'(rd_q) + i)];
        end
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      out_num_d   = '0;
      out_data_d  = '0;
    end
    err_d = err_q || (bus.in_valid && (in_n > IN_ELEMS_MAX)) || (req_n > OUT_ELEMS_MAX);
    if (flush) begin
      wr_d        = '0;
      rd_d        = '0;
      level_d     = '0;
      out_valid_d = 1'b0;
      out_num_d   = '0;
      out_data_d  = '0;
      err_d       = 1'b0;
    end
    af_d = int'(level_d) >= AF_THRESH;
    ae_d = int'(level_d) <= AE_THRESH;
  end

  // storage array has no reset; contents are don't-care until written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      out_data_q  <= '0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_num_q   <= out_num_d;
      out_data_q  <= out_data_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_num_elems = out_num_q;
  assign bus.out_data      = out_data_q;
  assign level             = level_q;
  assign almost_full       = af_q;
  assign almost_empty      = ae_q;
  assign err_req           = err_q;
endmodule

// File: doc/vivo_fifo_pp.md
Name: vivo_fifo_pp

Overview:
Second-generation variable-input/variable-output element FIFO. It accepts 1..IN_ELEMS_MAX elements per push and delivers up to OUT_ELEMS_MAX elements per pop through a registered output stage that holds its data stable under backpressure. Over the first generation it adds:
- optional partial pops
- synchronous flush
- programmable almost-full/almost-empty flags
- a sticky illegal-request error
It sits between variable-rate packers/unpackers in the datapath.

Parameters:
ELEM_WIDTH, 8, bits per element
DEPTH, 16, storage rows; CAPACITY = DEPTH*BANKS, BANKS = max(IN_ELEMS_MAX, OUT_ELEMS_MAX)
IN_ELEMS_MAX, 4, max elements per push
OUT_ELEMS_MAX, 4, max elements per pop
PARTIAL_POP, 1, 1: deliver min(req, level) when level>0; 0: wait until level >= req
AF_THRESH, CAPACITY-IN_ELEMS_MAX, almost_full asserted when level >= AF_THRESH
AE_THRESH, OUT_ELEMS_MAX, almost_empty asserted when level <= AE_THRESH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of storage, output stage and error flag
in_valid  in  1  push request
in_ready  out  1  push accepted when in_valid && in_ready
in_data  in  IN_ELEMS_MAX*ELEM_WIDTH  element j in slice j; element 0 is oldest
in_num_elems  in  clog2(IN_ELEMS_MAX+1)  elements in this push
out_valid  out  1  output stage holds data
out_ready  in  1  consumer accepts output stage
out_data  out  OUT_ELEMS_MAX*ELEM_WIDTH  element i in slice i; unused slices zero
out_num_elems  out  clog2(OUT_ELEMS_MAX+1)  valid elements in out_data; 0 when !out_valid
out_req_elems  in  clog2(OUT_ELEMS_MAX+1)  elements requested for the next load
level  out  clog2(CAPACITY+1)  elements in storage, excluding the output stage
almost_full  out  1  registered level >= AF_THRESH
almost_empty  out  1  registered level <= AE_THRESH
err_req  out  1  sticky: in_valid with in_num_elems > IN_ELEMS_MAX, or out_req_elems > OUT_ELEMS_MAX

Behaviour:
- Reset (async, rst_n=0): pointers, level, out_valid, out_num_elems, out_data, err_req all 0; almost_empty=1; almost_full=0. Storage contents are don't-care.
- Push acceptance:
  - in_ready = !flush && in_num_elems != 0 && in_num_elems <= IN_ELEMS_MAX && in_num_elems <= CAPACITY - level.
  - in_ready is combinational and does not depend on in_valid.
  - On do_push, element j is written at (wr_idx+j) mod CAPACITY; wr_idx advances by in_num_elems mod CAPACITY.
- Output stage loads when (!out_valid || out_ready) && !flush && a grant exists:
  - Grant requires out_req_elems in 1..OUT_ELEMS_MAX.
  - PARTIAL_POP=1: grant n = min(out_req_elems, level) if level > 0.
  - PARTIAL_POP=0: grant n = out_req_elems if level >= out_req_elems.
  - On load: out_data[i] = storage[(rd_idx+i) mod CAPACITY] for i < n, other slices 0; out_num_elems = n; out_valid = 1; rd_idx advances by n. Elements leave storage at load.
- out_ready && out_valid with no load that cycle: out_valid <- 0 next cycle.
- Back-to-back: a pop and a new load in the same cycle sustain one transfer per cycle.
- Hold: while out_valid && !out_ready, out_data and out_num_elems are stable regardless of out_req_elems.
- Latency: a push in cycle t is eligible for load at edge t+1 (load uses pre-push level); out_valid rises at edge t+2 at the earliest. No push-to-output bypass.
- Level: level_next = level + push_n - load_n; simultaneous push and load are both honoured. Flags are registered from level_next.
- Wrap: all index arithmetic is modulo CAPACITY. Pushes and loads that straddle the end of storage are split element-wise with no bubble.
- Full: level == CAPACITY forces in_ready=0. Empty: level == 0 means no load.
- Flush (sync, priority over everything):
  - Next cycle: pointers, level, out_valid, out_num_elems, out_data and err_req are all 0.
  - A push or pop in the flush cycle is discarded.
- Illegal requests: out_req_elems > OUT_ELEMS_MAX gives no grant. Either illegal condition (see err_req) sets err_req, which clears only on flush or reset.
- Reset asserted mid-transfer: immediate async clear; in-flight data is lost.

Test Plan:
- Defaults (CAPACITY=16*4=64). Push 3 elems {A0,A1,A2}, req=4, PARTIAL_POP=1, out_ready=0 -> out_valid=1, out_num_elems=3, out_data={0,A2,A1,A0}, level=0; data stays stable 5 cycles while out_ready=0.
- PARTIAL_POP=0. Push 2 then 2 more elements, req=4 -> no out_valid after the first push; after the second push out_valid=1, out_num_elems=4, level=0.
- 16 pushes of 4 -> level=64, in_ready=0 for in_num_elems=1, almost_full=1. Then out_ready=1, req=4 for 16 cycles -> 16 consecutive valid beats in order, no bubbles.
- Wrap: set wr_idx=62 via preload/drain. Push 4 -> elements land at 62,63,0,1; pop req=4 returns them in order.
- Simultaneous push of 4 and load of 4 at level=8 -> level stays 8. Flush the next cycle -> level=0, out_valid=0, almost_empty=1.
- in_valid with in_num_elems=5 -> in_ready=0, err_req=1 held until flush.
